tlul_tempsensor_ctrl: RTL and testbench
=======================================

TLUL_TEMPSENSOR_CTRL -- requirements
Module: tlul_tempsensor_ctrl

Interface
REQ-001 SHALL have parameter NumCh, default 4, meaning the number of sensor channels (1..8).
REQ-002 SHALL have parameter DoutW, default 24, meaning the sensor result width (at most 31).
REQ-003 SHALL have parameter TimeoutW, default 16, meaning the width of the conversion timeout counter.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is synchronous to it.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port tl_i, input, tl_h2d_t: TL-UL host request.
REQ-007 SHALL have port tl_o, output, tl_d2h_t: TL-UL device response.
REQ-008 SHALL have port sens_rst_no, output, NumCh bits: per-channel sensor counter reset, active-low.
REQ-009 SHALL have port sens_en_o, output, NumCh bits: per-channel sensor enable.
REQ-010 SHALL have port sens_conv_time_o, output, 4 bits: conversion-time select shared by all channels.
REQ-011 SHALL have port sens_dout_i, input, NumCh*DoutW bits: per-channel results, already synchronised to clk_i externally.
REQ-012 SHALL have port sens_done_i, input, NumCh bits: per-channel done flags, already synchronised.
REQ-013 SHALL have port intr_o, output, 1 bit: level interrupt, equal to (scan-done OR any alert OR timeout) AND the corresponding enable.

Function
REQ-014 SHALL implement the following register map; all registers are word-aligned.
- 0x00 CTRL (RW): [0] start (write-1 pulse, reads 0), [1] continuous, [7:4] conv_time.
- 0x04 CH_EN (RW): [NumCh-1:0] channel mask.
- 0x08 STATUS (RO): [0] busy, [1] scan_done, [2] timeout, [15:8] alert per channel.
- 0x0C THRESH (RW): [DoutW-1:0] alert threshold.
- 0x10 INTR_EN (RW): [0] scan_done, [1] alert, [2] timeout.
- 0x14 CLR (W1C): clears the STATUS bits at the matching positions [1], [2] and [15:8].
- 0x20+4*ch RESULT[ch] (RO): [DoutW-1:0] last value, [31] valid.
REQ-015 SHALL accept one TL request at a time. a_ready = ~outstanding. The response is given on the cycle after a_ack. d_valid stays high until d_ready.
REQ-016 SHALL respond with d_error=1 on any of: misaligned address, unmapped address, a write to an RO register, a_mask not all-ones on a write, or the tlul_err checker firing. An errored write SHALL NOT change any state. An errored read SHALL return all-ones data.
REQ-017 SHALL return AccessAckData for Get and AccessAck for PutFullData/PutPartialData.
REQ-018 SHALL implement scan FSM states IDLE, RST, CONV, STORE, NEXT, DONE.
REQ-019 IDLE->RST SHALL occur on a start write when CH_EN != 0. A start with CH_EN == 0 SHALL set scan_done immediately.
REQ-020 In RST, sens_rst_no[ch] SHALL be low for exactly 2 cycles, then the FSM SHALL go to CONV.
REQ-021 In CONV, sens_en_o[ch] SHALL be 1 and the timeout counter SHALL increment. On sens_done_i[ch] the FSM SHALL go to STORE. On counter all-ones it SHALL set timeout, write RESULT[ch] = all-ones with valid=0, and go to NEXT.
REQ-022 STORE SHALL latch sens_dout_i[ch] into RESULT[ch] with valid=1, and SHALL set alert[ch] if value >= THRESH (unsigned compare).
REQ-023 NEXT SHALL select the next higher enabled channel; if none remains it SHALL go to DONE.
REQ-024 DONE SHALL set scan_done for 1 cycle of FSM time. It SHALL then go to RST on the lowest enabled channel if continuous=1 and CH_EN != 0; otherwise it SHALL go to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 A start written while busy SHALL be ignored. Writes to CH_EN, conv_time or THRESH while busy SHALL take effect from the next NEXT/DONE decision onward.
REQ-027 Clearing continuous while busy SHALL let the current scan finish, then go to IDLE.
REQ-028 When a hardware set and a CLR write hit the same status bit in the same cycle, the set SHALL win.
REQ-029 Only the channel being serviced SHALL have sens_en_o asserted; all other channels SHALL keep sens_rst_no high and sens_en_o low.

Reset
REQ-030 On rst_ni low, all registers SHALL be 0, RESULT valid SHALL be 0, and the FSM SHALL be in IDLE with outstanding=0.
REQ-031 During reset, sens_rst_no SHALL be all-ones, sens_en_o SHALL be 0, and intr_o, a_ready-gating and d_valid SHALL be 0.
REQ-032 Reset asserted mid-scan SHALL abort immediately with no partial RESULT update.

Structure
REQ-033 Register offsets, field positions and the FSM state enum SHALL live in tempsensor_ctrl_pkg.
REQ-034 The scan FSM, timeout counter and result capture SHALL be the sub-module tempsensor_scan; the TL decode and registers SHALL stay in the top level.

Verification
REQ-035 Bench SHALL cover: CH_EN=0b0101, start -> ch0 then ch2 converted; RESULT0 and RESULT2 valid; RESULT1 valid=0; scan_done=1.
REQ-036 Bench SHALL cover: THRESH=0x100, ch0 dout=0x100 -> alert[0]=1; with INTR_EN.alert=1, intr_o=1; CLR 0x100 -> alert[0]=0 and intr_o=0.
REQ-037 Bench SHALL cover: done held low, TimeoutW=4 -> timeout=1 after 15 CONV cycles; RESULT=all-ones with valid=0; the scan continues to the next channel.
REQ-038 Bench SHALL cover: read 0x02, write 0x08 and read 0x40 -> d_error=1; no state change.
REQ-039 Bench SHALL cover: continuous=1 -> a second scan starts with no second start write; clear continuous -> IDLE after the scan completes.
REQ-040 Bench SHALL cover: rst_ni pulsed during CONV -> all outputs at reset values within the same cycle; no RESULT written.

Source files
------------

// File: rtl/tempsensor_ctrl_pkg.sv
// tempsensor_ctrl_pkg: TL-UL types, register map, field positions and scan states
package tempsensor_ctrl_pkg;
   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;
   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
   localparam logic [2:0] PUT_FULL = 3'd0, PUT_PART = 3'd1, GET = 3'd4;
   localparam logic [2:0] ACK = 3'd0, ACK_DATA = 3'd1;
   localparam logic [7:0] CTRL_OFS = 8'h00, CHEN_OFS = 8'h04, STATUS_OFS = 8'h08;
   localparam logic [7:0] THRESH_OFS = 8'h0C, INTREN_OFS = 8'h10, CLR_OFS = 8'h14;
   localparam int CTRL_START = 0, CTRL_CONT = 1, CTRL_CT = 4;
   localparam int ST_BUSY = 0, ST_DONE = 1, ST_TO = 2, ST_ALERT = 8;
   localparam int IE_DONE = 0, IE_ALERT = 1, IE_TO = 2;
   typedef enum logic [2:0] {S_IDLE, S_RST, S_CONV, S_STORE, S_NEXT, S_DONE} scan_state_e;
endpackage

// File: rtl/tempsensor_scan.sv
// tempsensor_scan: channel scan FSM, conversion timeout and result capture
module tempsensor_scan
   import tempsensor_ctrl_pkg::*;
#(
   parameter int NumCh    = 4,
   parameter int DoutW    = 24,
   parameter int TimeoutW = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic                       i_continuous,
   input  logic [NumCh-1:0]           i_ch_en,
   input  logic [NumCh-1:0]           i_done,
   input  logic [NumCh*DoutW-1:0]     i_dout,
   input  logic [DoutW-1:0]           i_thresh,
   output logic                       o_busy,
   output logic                       o_done_set,
   output logic                       o_timeout_set,
   output logic [NumCh-1:0]           o_alert_set,
   output logic [NumCh-1:0]           o_rst_n,
   output logic [NumCh-1:0]           o_en,
   output logic [NumCh*(DoutW+1)-1:0] o_result
);
   localparam int ChW = NumCh > 1 ? $clog2(NumCh) : 1;
   scan_state_e r_state;
   logic [ChW-1:0] r_ch, w_low_ch, w_nxt_ch, w_go_ch;
   logic w_nxt_vld, w_go, r_rst_cnt, w_hit, w_to;
   logic [TimeoutW-1:0] r_cnt;
   logic [DoutW-1:0] w_dout;
   logic [NumCh-1:0] w_oh;
   logic [DoutW:0] r_result [NumCh];
   always_comb begin
      w_low_ch  = '0;
      w_nxt_ch  = '0;
      w_nxt_vld = 1'b0;
      for (int i = NumCh - 1; i >= 0; i--) begin
         if (i_ch_en[i]) w_low_ch = ChW'(i);
         if (i_ch_en[i] && ChW'(i) > r_ch) begin
            w_nxt_ch  = ChW'(i);
            w_nxt_vld = 1'b1;
         end
      end
   end
   assign w_dout        = i_dout[int'(r_ch)*DoutW +: DoutW];
   assign w_hit         = i_done[r_ch];
   assign w_to          = &r_cnt;
   assign w_oh          = NumCh'(1) << r_ch;
   assign o_busy        = r_state != S_IDLE;
   assign o_done_set    = r_state == S_DONE || (r_state == S_IDLE && i_start && ~|i_ch_en);
   assign o_timeout_set = r_state == S_CONV && !w_hit && w_to;
   assign o_alert_set   = (r_state == S_STORE && w_dout >= i_thresh) ? w_oh : '0;
   // every entry into RST funnels through one path so the reset pulse is always two cycles
   assign w_go    = (r_state == S_IDLE && i_start && |i_ch_en) || (r_state == S_NEXT && w_nxt_vld) ||
                    (r_state == S_DONE && i_continuous && |i_ch_en);
   assign w_go_ch = r_state == S_NEXT ? w_nxt_ch : w_low_ch;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_ch      <= '0;
         r_rst_cnt <= 1'b0;
         r_cnt     <= '0;
         o_rst_n   <= '1;
         o_en      <= '0;
      end else if (w_go) begin
         r_state   <= S_RST;
         r_ch      <= w_go_ch;
         r_rst_cnt <= 1'b0;
         o_rst_n   <= ~(NumCh'(1) << w_go_ch);
      end else begin
         case (r_state)
            S_RST: begin
               r_rst_cnt <= 1'b1;
               if (r_rst_cnt) begin
                  r_state <= S_CONV;
                  r_cnt   <= '0;
                  o_rst_n <= '1;
                  o_en    <= w_oh;
               end
            end
            S_CONV: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_hit || w_to) begin
                  r_state <= w_hit ? S_STORE : S_NEXT;
                  o_en    <= '0;
               end
            end
            S_STORE: r_state <= S_NEXT;
            S_NEXT:  r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NumCh; i++) r_result[i] <= '0;
      end else if (r_state == S_STORE) begin
         r_result[r_ch] <= {1'b1, w_dout};
      end else if (o_timeout_set) begin
         r_result[r_ch] <= {1'b0, {DoutW{1'b1}}};
      end
   end
   always_comb begin
      o_result = '0;
      for (int i = 0; i < NumCh; i++) o_result[i*(DoutW+1) +: DoutW+1] = r_result[i];
   end
endmodule

// File: rtl/tlul_tempsensor_ctrl.sv
// tlul_tempsensor_ctrl: TL-UL register front end and status/interrupt logic for the sensor scanner
module tlul_tempsensor_ctrl
   import tempsensor_ctrl_pkg::*;
#(
   parameter int NumCh    = 4,
   parameter int DoutW    = 24,
   parameter int TimeoutW = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  tl_h2d_t                tl_i,
   output tl_d2h_t                tl_o,
   output logic [NumCh-1:0]       sens_rst_no,
   output logic [NumCh-1:0]       sens_en_o,
   output logic [3:0]             sens_conv_time_o,
   input  logic [NumCh*DoutW-1:0] sens_dout_i,
   input  logic [NumCh-1:0]       sens_done_i,
   output logic                   intr_o
);
   logic r_outstanding, r_d_error, r_continuous, r_scan_done, r_timeout;
   logic [2:0] r_d_opcode, r_intr_en;
   logic [1:0] r_d_size;
   logic [7:0] r_d_source;
   logic [31:0] r_d_data;
   logic [3:0] r_conv_time;
   logic [NumCh-1:0] r_ch_en, r_alert, w_alert_set;
   logic [DoutW-1:0] r_thresh;
   logic w_ack, w_we, w_re, w_legal, w_is_res, w_mapped, w_ro, w_err, w_wr, w_start;
   logic w_busy, w_done_set, w_to_set, w_unused;
   logic [7:0] w_addr;
   logic [31:0] w_clr, w_rdata, w_ctrl, w_st;
   logic [NumCh*(DoutW+1)-1:0] w_result;
   logic [DoutW:0] w_res_sel;
   assign w_ack     = tl_i.a_valid & ~r_outstanding;
   assign w_we      = tl_i.a_opcode == PUT_FULL || tl_i.a_opcode == PUT_PART;
   assign w_re      = tl_i.a_opcode == GET;
   assign w_legal   = (w_we || w_re) && tl_i.a_size <= 2'd2;
   assign w_addr    = tl_i.a_address[7:0];
   assign w_is_res  = w_addr[7:5] == 3'b001 && int'(w_addr[4:2]) < NumCh;
   assign w_mapped  = ~|tl_i.a_address[31:8] && (w_is_res || w_addr == CTRL_OFS || w_addr == CHEN_OFS ||
                      w_addr == STATUS_OFS || w_addr == THRESH_OFS || w_addr == INTREN_OFS || w_addr == CLR_OFS);
   assign w_ro      = w_addr == STATUS_OFS || w_is_res;
   assign w_err     = !w_legal || |w_addr[1:0] || !w_mapped || (w_we && w_ro) || (w_we && !(&tl_i.a_mask));
   assign w_wr      = w_ack && w_we && !w_err;
   assign w_start   = w_wr && w_addr == CTRL_OFS && tl_i.a_data[CTRL_START];
   assign w_clr     = (w_wr && w_addr == CLR_OFS) ? tl_i.a_data : '0;
   assign w_res_sel = w_result[int'(w_addr[4:2])*(DoutW+1) +: DoutW+1];
   assign w_unused  = ^tl_i.a_param;
   always_comb begin
      w_ctrl                  = '0;
      w_ctrl[CTRL_CONT]       = r_continuous;
      w_ctrl[CTRL_CT +: 4]    = r_conv_time;
      w_st                    = '0;
      w_st[ST_BUSY]           = w_busy;
      w_st[ST_DONE]           = r_scan_done;
      w_st[ST_TO]             = r_timeout;
      w_st[ST_ALERT +: NumCh] = r_alert;
      w_rdata                 = '0;
      case (w_addr)
         CTRL_OFS:   w_rdata = w_ctrl;
         CHEN_OFS:   w_rdata = 32'(r_ch_en);
         STATUS_OFS: w_rdata = w_st;
         THRESH_OFS: w_rdata = 32'(r_thresh);
         INTREN_OFS: w_rdata = 32'(r_intr_en);
         default:    w_rdata = w_is_res ? {w_res_sel[DoutW], 31'(w_res_sel[DoutW-1:0])} : '0;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_outstanding <= 1'b0;
         r_d_opcode    <= ACK;
         r_d_error     <= 1'b0;
         r_d_data      <= '0;
         r_d_source    <= '0;
         r_d_size      <= '0;
      end else if (w_ack) begin
         r_outstanding <= 1'b1;
         r_d_opcode    <= w_re ? ACK_DATA : ACK;
         r_d_error     <= w_err;
         r_d_data      <= w_err ? {32{w_re}} : (w_re ? w_rdata : '0);
         r_d_source    <= tl_i.a_source;
         r_d_size      <= tl_i.a_size;
      end else if (r_outstanding && tl_i.d_ready) begin
         r_outstanding <= 1'b0;
      end
   end
   // hardware sets are OR-ed in after the clear so a same-cycle event is never lost
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_continuous <= 1'b0;
         r_conv_time  <= '0;
         r_ch_en      <= '0;
         r_thresh     <= '0;
         r_intr_en    <= '0;
         r_scan_done  <= 1'b0;
         r_timeout    <= 1'b0;
         r_alert      <= '0;
      end else begin
         if (w_wr && w_addr == CTRL_OFS) begin
            r_continuous <= tl_i.a_data[CTRL_CONT];
            r_conv_time  <= tl_i.a_data[CTRL_CT +: 4];
         end
         if (w_wr && w_addr == CHEN_OFS) r_ch_en <= tl_i.a_data[NumCh-1:0];
         if (w_wr && w_addr == THRESH_OFS) r_thresh <= tl_i.a_data[DoutW-1:0];
         if (w_wr && w_addr == INTREN_OFS) r_intr_en <= tl_i.a_data[2:0];
         r_scan_done <= (r_scan_done & ~w_clr[ST_DONE]) | w_done_set;
         r_timeout   <= (r_timeout & ~w_clr[ST_TO]) | w_to_set;
         r_alert     <= (r_alert & ~w_clr[ST_ALERT +: NumCh]) | w_alert_set;
      end
   end
   always_comb begin
      tl_o          = '0;
      tl_o.a_ready  = ~r_outstanding;
      tl_o.d_valid  = r_outstanding;
      tl_o.d_opcode = r_d_opcode;
      tl_o.d_size   = r_d_size;
      tl_o.d_source = r_d_source;
      tl_o.d_data   = r_d_data;
      tl_o.d_error  = r_d_error;
   end
   assign intr_o = (r_scan_done & r_intr_en[IE_DONE]) | (|r_alert & r_intr_en[IE_ALERT]) |
                   (r_timeout & r_intr_en[IE_TO]);
   assign sens_conv_time_o = r_conv_time;
   tempsensor_scan #(.NumCh(NumCh), .DoutW(DoutW), .TimeoutW(TimeoutW)) u_scan (
      .i_clk         (clk_i),
      .i_rst_n       (rst_ni),
      .i_start       (w_start),
      .i_continuous  (r_continuous),
      .i_ch_en       (r_ch_en),
      .i_done        (sens_done_i),
      .i_dout        (sens_dout_i),
      .i_thresh      (r_thresh),
      .o_busy        (w_busy),
      .o_done_set    (w_done_set),
      .o_timeout_set (w_to_set),
      .o_alert_set   (w_alert_set),
      .o_rst_n       (sens_rst_no),
      .o_en          (sens_en_o),
      .o_result      (w_result)
   );
endmodule

// File: tb/tb_tlul_tempsensor_ctrl.sv
// tb_tlul_tempsensor_ctrl: scoreboard bench with a behavioural sensor model
module tb_tlul_tempsensor_ctrl;
   import tempsensor_ctrl_pkg::*;
   localparam int NumCh = 4, DoutW = 24, TimeoutW = 4;
   typedef struct {
      logic        rd;
      logic        err;
      logic [31:0] data;
   } exp_t;
   logic clk = 1'b0, rst_ni = 1'b0;
   tl_h2d_t tl_i;
   tl_d2h_t tl_o;
   logic [NumCh-1:0] sens_rst_no, sens_en_o, sens_done_i, en_prev;
   logic [3:0] sens_conv_time_o;
   logic [NumCh*DoutW-1:0] sens_dout_i;
   logic intr_o, multi_en = 1'b0;
   logic [DoutW-1:0] dout [NumCh];
   int lat [NumCh], cnt [NumCh], episodes [NumCh], rlow [NumCh];
   int order [$];
   exp_t q [$];
   string qn [$];
   int n_cmp = 0, n_fail = 0;
   assign sens_dout_i = {dout[3], dout[2], dout[1], dout[0]};
   tlul_tempsensor_ctrl #(.NumCh(NumCh), .DoutW(DoutW), .TimeoutW(TimeoutW)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .tl_i             (tl_i),
      .tl_o             (tl_o),
      .sens_rst_no      (sens_rst_no),
      .sens_en_o        (sens_en_o),
      .sens_conv_time_o (sens_conv_time_o),
      .sens_dout_i      (sens_dout_i),
      .sens_done_i      (sens_done_i),
      .intr_o           (intr_o)
   );
   initial forever #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", n, act, exp);
      end
   endtask
   // monitor: pops one expectation per completed TL response
   initial begin
      exp_t e;
      string n;
      forever begin
         @(negedge clk);
         if (tl_o.d_valid && tl_i.d_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_rsp: got a response, required none");
            end else begin
               e = q.pop_front();
               n = qn.pop_front();
               if (tl_o.d_error !== e.err || tl_o.d_opcode !== (e.rd ? ACK_DATA : ACK) ||
                   (e.rd && tl_o.d_data !== e.data)) begin
                  n_fail++;
                  $display("FAIL %s: got err=%b op=%0d data=%h required err=%b op=%0d data=%h", n,
                           tl_o.d_error, tl_o.d_opcode, tl_o.d_data, e.err, e.rd ? ACK_DATA : ACK, e.data);
               end
            end
         end
      end
   end
   // sensor model: done after lat[ch] enabled cycles (lat 0 = never), also logs reset pulse lengths
   initial begin
      sens_done_i = '0;
      en_prev     = '0;
      for (int c = 0; c < NumCh; c++) begin
         cnt[c] = 0;
         episodes[c] = 0;
         rlow[c] = 0;
      end
      forever begin
         @(negedge clk);
         if ($countones(sens_en_o) > 1) multi_en = 1'b1;
         for (int c = 0; c < NumCh; c++) begin
            if (sens_en_o[c]) begin
               if (!en_prev[c]) begin
                  order.push_back(c);
                  episodes[c]++;
                  cnt[c] = 0;
               end
               cnt[c]++;
               sens_done_i[c] = lat[c] != 0 && cnt[c] >= lat[c];
            end else begin
               sens_done_i[c] = 1'b0;
            end
            if (!sens_rst_no[c]) rlow[c]++;
            else if (rlow[c] != 0) begin
               chk($sformatf("rst_len_ch%0d", c), rlow[c], 2);
               rlow[c] = 0;
            end
         end
         en_prev = sens_en_o;
      end
   end
   task automatic tl(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] mask, input logic err, input logic [31:0] exp, input string n);
      exp_t e;
      int k = 0;
      e.rd = op == GET;
      e.err = err;
      e.data = exp;
      q.push_back(e);
      qn.push_back(n);
      @(negedge clk);
      tl_i.a_valid   = 1'b1;
      tl_i.a_opcode  = op;
      tl_i.a_address = addr;
      tl_i.a_data    = data;
      tl_i.a_mask    = mask;
      while (!tl_o.a_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: a_ready stayed low, required high", n);
      end
      @(negedge clk);
      tl_i.a_valid = 1'b0;
      @(negedge clk);
   endtask
   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string n);
      tl(PUT_FULL, addr, data, 4'hf, 1'b0, 32'h0, n);
   endtask
   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string n);
      tl(GET, addr, 32'h0, 4'hf, 1'b0, exp, n);
   endtask
   initial begin
      int e0, k;
      tl_i = '0;
      tl_i.d_ready = 1'b1;
      tl_i.a_size  = 2'd2;
      dout[0] = 24'h000100;
      dout[1] = 24'h000077;
      dout[2] = 24'h000050;
      dout[3] = 24'h000123;
      for (int c = 0; c < NumCh; c++) lat[c] = 3;
      repeat (3) @(negedge clk);
      chk("rst_sens_rst_no", 32'(sens_rst_no), 32'hf);
      chk("rst_sens_en", 32'(sens_en_o), 32'h0);
      chk("rst_intr", 32'(intr_o), 32'h0);
      chk("rst_d_valid", 32'(tl_o.d_valid), 32'h0);
      rst_ni = 1'b1;
      rd(32'h00, 32'h0, "rst_ctrl");
      rd(32'h04, 32'h0, "rst_chen");
      rd(32'h08, 32'h0, "rst_status");
      rd(32'h0C, 32'h0, "rst_thresh");
      rd(32'h20, 32'h0, "rst_result0");
      // two-channel scan with one alert
      wr(32'h0C, 32'h100, "wr_thresh");
      wr(32'h04, 32'h5, "wr_chen5");
      wr(32'h00, 32'h1, "wr_start");
      repeat (60) @(negedge clk);
      rd(32'h08, 32'h102, "scan_status");
      rd(32'h20, 32'h80000100, "scan_result0");
      rd(32'h24, 32'h0, "scan_result1");
      rd(32'h28, 32'h80000050, "scan_result2");
      rd(32'h2C, 32'h0, "scan_result3");
      chk("scan_order", order.size() == 2 ? 32'(order[0] * 16 + order[1]) : 32'hff, 32'h02);
      // interrupts
      wr(32'h10, 32'h2, "wr_intren_alert");
      chk("intr_alert", 32'(intr_o), 32'h1);
      wr(32'h14, 32'h100, "clr_alert0");
      chk("intr_alert_clr", 32'(intr_o), 32'h0);
      rd(32'h08, 32'h2, "status_after_clr");
      wr(32'h10, 32'h1, "wr_intren_done");
      chk("intr_done", 32'(intr_o), 32'h1);
      wr(32'h14, 32'h2, "clr_done");
      chk("intr_done_clr", 32'(intr_o), 32'h0);
      rd(32'h08, 32'h0, "status_clr_all");
      // error responses leave state untouched
      tl(GET, 32'h02, 32'h0, 4'hf, 1'b1, 32'hffffffff, "err_misaligned_rd");
      tl(PUT_FULL, 32'h08, 32'hff, 4'hf, 1'b1, 32'h0, "err_wr_status");
      tl(GET, 32'h40, 32'h0, 4'hf, 1'b1, 32'hffffffff, "err_unmapped_rd");
      tl(PUT_PART, 32'h04, 32'h3, 4'h3, 1'b1, 32'h0, "err_partial_mask");
      tl(PUT_FULL, 32'h20, 32'h0, 4'hf, 1'b1, 32'h0, "err_wr_result");
      rd(32'h04, 32'h5, "chen_unchanged");
      rd(32'h08, 32'h0, "status_unchanged");
      rd(32'h00, 32'h0, "ctrl_unchanged");
      // channel 1 never finishes: timeout then channel 2 still scanned
      lat[1] = 0;
      order.delete();
      wr(32'h04, 32'h6, "wr_chen6");
      wr(32'h00, 32'h1, "wr_start_to");
      repeat (60) @(negedge clk);
      rd(32'h08, 32'h6, "to_status");
      rd(32'h24, 32'h00ffffff, "to_result1");
      rd(32'h28, 32'h80000050, "to_result2");
      chk("to_order", order.size() == 2 ? 32'(order[0] * 16 + order[1]) : 32'hff, 32'h12);
      wr(32'h14, 32'h106, "clr_to");
      rd(32'h08, 32'h0, "to_status_clr");
      lat[1] = 3;
      // start with no channels enabled
      wr(32'h04, 32'h0, "wr_chen0");
      wr(32'h00, 32'h1, "wr_start_empty");
      rd(32'h08, 32'h2, "empty_scan_done");
      wr(32'h14, 32'h2, "clr_empty");
      // continuous mode
      wr(32'h04, 32'h1, "wr_chen1");
      e0 = episodes[0];
      wr(32'h00, 32'h3, "wr_start_cont");
      repeat (40) @(negedge clk);
      chk("cont_rescan", 32'((episodes[0] - e0) >= 2), 32'h1);
      wr(32'h00, 32'h0, "wr_stop_cont");
      repeat (40) @(negedge clk);
      rd(32'h08, 32'h102, "cont_stopped_status");
      e0 = episodes[0];
      repeat (30) @(negedge clk);
      chk("cont_idle", 32'(episodes[0] - e0), 32'h0);
      wr(32'h00, 32'h50, "wr_conv_time");
      chk("conv_time_out", 32'(sens_conv_time_o), 32'h5);
      rd(32'h00, 32'h50, "rd_conv_time");
      chk("intr_before_rst", 32'(intr_o), 32'h1);
      // reset in the middle of a conversion
      lat[0] = 0;
      wr(32'h00, 32'h1, "wr_start_rst");
      k = 0;
      while (!sens_en_o[0] && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("conv_reached", 32'(sens_en_o[0]), 32'h1);
      repeat (3) @(negedge clk);
      #2 rst_ni = 1'b0;
      #1;
      chk("midrst_sens_rst_no", 32'(sens_rst_no), 32'hf);
      chk("midrst_sens_en", 32'(sens_en_o), 32'h0);
      chk("midrst_intr", 32'(intr_o), 32'h0);
      chk("midrst_d_valid", 32'(tl_o.d_valid), 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;
      rd(32'h20, 32'h0, "midrst_result0");
      rd(32'h08, 32'h0, "midrst_status");
      rd(32'h04, 32'h0, "midrst_chen");
      rd(32'h10, 32'h0, "midrst_intren");
      k = 0;
      while (q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("pending_rsp", 32'(q.size()), 32'h0);
      chk("single_enable", 32'(multi_en), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
